instr_mem_responder: RTL and testbench

- Responder end of the core's instruction-fetch port: receives the fetch address, enable (stall) and flush, and returns the instruction word one clock later.
- Its output register is the IF/DE instruction register, so it honours stall (hold) and flush (bubble) exactly.
- Includes a boot/reload loader with a valid/ready handshake that fills the instruction store and holds the core in reset until loading completes.
- Sits beside core_top at SoC level, between the program loader (UART/JTAG bridge) and the core.

---
 rtl/instr_mem_responder.sv | 108 ++++++++++
 tb/tb_instr_mem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: 1-cycle registered read honouring stall/flush, plus a
// valid/ready boot loader that fills the store and holds the core in reset while loading.
module instr_mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
    parameter bit          BOOT_LOAD = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             instr_memory_addr,
    input  logic                    instr_memory_enable,
    input  logic                    instr_memory_flush,
    output logic [31:0]             instr_memory_data,
    input  logic                    load_valid,
    input  logic [31:0]             load_data,
    input  logic                    load_last,
    output logic                    load_ready,
    input  logic                    reload,
    output logic                    core_hold,
    output logic [$clog2(DEPTH):0]  load_count,
    output logic                    load_overflow,
    output logic                    addr_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

    state_t         r_state;
    logic [31:0]    r_store [DEPTH];
    logic [31:0]    r_data;
    logic [CW-1:0]  r_count;
    logic           r_overflow;
    logic           r_fault;

    logic           w_loading;
    logic           w_hs;
    logic           w_room;
    logic           w_misaligned;
    logic           w_out_of_range;
    logic [AW-1:0]  w_index;

    assign w_loading      = (r_state == S_LOAD);
    assign w_hs           = load_valid & w_loading;
    assign w_room         = (r_count < CW'(DEPTH));
    assign w_index        = instr_memory_addr[AW+1:2];
    assign w_misaligned   = |instr_memory_addr[1:0];
    assign w_out_of_range = |instr_memory_addr[31:AW+2];

    // Store has no reset so a partial image survives a reset mid-load.
    always_ff @(posedge clk) begin
        if (w_hs && w_room) begin
            r_store[r_count[AW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= BOOT_LOAD ? S_LOAD : S_RUN;
            r_data     <= NOP_WORD;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_data <= NOP_WORD;
                    if (w_hs) begin
                        if (!w_room) begin
                            r_overflow <= 1'b1;
                        end
                        if (r_count != '1) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (load_last) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                default: begin
                    // Reload outranks any fetch presented in the same cycle.
                    if (reload) begin
                        r_state    <= S_LOAD;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_data     <= NOP_WORD;
                    end else if (instr_memory_flush) begin
                        r_data <= NOP_WORD;
                    end else if (instr_memory_enable) begin
                        if (w_misaligned || w_out_of_range) begin
                            r_data  <= NOP_WORD;
                            r_fault <= 1'b1;
                        end else begin
                            r_data <= r_store[w_index];
                        end
                    end
                end
            endcase
        end
    end

    assign load_ready        = w_loading;
    assign core_hold         = w_loading;
    assign instr_memory_data = r_data;
    assign load_count        = r_count;
    assign load_overflow     = r_overflow;
    assign addr_fault        = r_fault;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: directed and random steps against a behavioural model.
module tb_instr_mem_responder;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          MD  = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (DEPTH=1024, BOOT_LOAD=1)
    logic        reset, en, flush, lv, ll, rel;
    logic [31:0] addr, ld;
    logic [31:0] d_data;
    logic        d_ready, d_hold, d_ovf, d_fault;
    logic [10:0] d_count;

    // small instance (DEPTH=4)
    logic        s_reset, s_en, s_flush, s_lv, s_ll, s_rel;
    logic [31:0] s_addr, s_ld;
    logic [31:0] s_data;
    logic        s_ready, s_hold, s_ovf, s_fault;
    logic [2:0]  s_count;

    // no-boot instance shares the main inputs
    logic [31:0] n_data;
    logic        n_ready, n_hold, n_ovf, n_fault;
    logic [4:0]  n_count;

    instr_mem_responder #(.DEPTH(MD), .NOP_WORD(NOP), .BOOT_LOAD(1'b1)) u_dut (
        .clk(clk), .reset(reset), .instr_memory_addr(addr), .instr_memory_enable(en),
        .instr_memory_flush(flush), .instr_memory_data(d_data), .load_valid(lv),
        .load_data(ld), .load_last(ll), .load_ready(d_ready), .reload(rel),
        .core_hold(d_hold), .load_count(d_count), .load_overflow(d_ovf), .addr_fault(d_fault));

    instr_mem_responder #(.DEPTH(4), .NOP_WORD(NOP), .BOOT_LOAD(1'b1)) u_small (
        .clk(clk), .reset(s_reset), .instr_memory_addr(s_addr), .instr_memory_enable(s_en),
        .instr_memory_flush(s_flush), .instr_memory_data(s_data), .load_valid(s_lv),
        .load_data(s_ld), .load_last(s_ll), .load_ready(s_ready), .reload(s_rel),
        .core_hold(s_hold), .load_count(s_count), .load_overflow(s_ovf), .addr_fault(s_fault));

    instr_mem_responder #(.DEPTH(16), .NOP_WORD(NOP), .BOOT_LOAD(1'b0)) u_noboot (
        .clk(clk), .reset(reset), .instr_memory_addr(addr), .instr_memory_enable(en),
        .instr_memory_flush(flush), .instr_memory_data(n_data), .load_valid(lv),
        .load_data(ld), .load_last(ll), .load_ready(n_ready), .reload(rel),
        .core_hold(n_hold), .load_count(n_count), .load_overflow(n_ovf), .addr_fault(n_fault));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural model of the main instance: "loading" flag, word array, counters.
    bit          m_loading;
    int          m_count;
    bit          m_ovf, m_fault;
    logic [31:0] m_out;
    logic [31:0] m_mem [int];

    function automatic void m_step();
        if (reset) begin
            m_loading = 1'b1; m_out = NOP; m_count = 0; m_ovf = 1'b0; m_fault = 1'b0;
        end else if (m_loading) begin
            m_out = NOP;
            if (lv) begin
                if (m_count < MD) m_mem[m_count] = ld;
                else m_ovf = 1'b1;
                if (m_count < 2 * MD - 1) m_count++;
                if (ll) m_loading = 1'b0;
            end
        end else if (rel) begin
            m_loading = 1'b1; m_count = 0; m_ovf = 1'b0; m_out = NOP;
        end else if (flush) begin
            m_out = NOP;
        end else if (en) begin
            if (addr[1:0] != 2'b00 || addr >= 32'(MD * 4)) begin
                m_out = NOP; m_fault = 1'b1;
            end else begin
                m_out = m_mem[int'(addr / 4)];
            end
        end
    endfunction

    task automatic cyc();
        m_step();
        @(posedge clk);
        #1;
        chk("data",  d_data, m_out);
        chk("hold",  {31'b0, d_hold}, {31'b0, m_loading});
        chk("ready", {31'b0, d_ready}, {31'b0, m_loading});
        chk("count", {21'b0, d_count}, 32'(m_count));
        chk("ovf",   {31'b0, d_ovf}, {31'b0, m_ovf});
        chk("fault", {31'b0, d_fault}, {31'b0, m_fault});
    endtask

    task automatic load_word(input logic [31:0] w, input logic last);
        lv = 1'b1; ld = w; ll = last;
        cyc();
        lv = 1'b0; ll = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic e, input logic f);
        addr = a; en = e; flush = f;
        cyc();
        en = 1'b0; flush = 1'b0;
    endtask

    task automatic s_cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] boot [4] = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h0000006F};
    logic [31:0] sw   [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0; lv = 1'b0; ll = 1'b0; rel = 1'b0;
        addr = '0; ld = '0;
        s_reset = 1'b1; s_en = 1'b0; s_flush = 1'b0; s_lv = 1'b0; s_ll = 1'b0;
        s_rel = 1'b0; s_addr = '0; s_ld = '0;

        // reset state
        cyc();
        chk("rst_hold", {31'b0, d_hold}, 32'd1);
        chk("rst_data", d_data, NOP);
        chk("noboot_hold", {31'b0, n_hold}, 32'd0);
        chk("noboot_ready", {31'b0, n_ready}, 32'd0);
        reset = 1'b0;

        // boot load
        for (int i = 0; i < 4; i++) load_word(boot[i], i == 3);
        chk("boot_count", {21'b0, d_count}, 32'd4);
        chk("boot_hold", {31'b0, d_hold}, 32'd0);
        fetch(32'h8, 1'b1, 1'b0);
        chk("fetch8", d_data, 32'h002081B3);

        // stall / flush
        fetch(32'h0, 1'b1, 1'b0);
        chk("fetch0", d_data, 32'h00500093);
        fetch(32'h4, 1'b0, 1'b0);
        chk("stall_hold", d_data, 32'h00500093);
        fetch(32'h4, 1'b1, 1'b1);
        chk("flush_en", d_data, NOP);
        fetch(32'h4, 1'b0, 1'b1);
        chk("flush_noen", d_data, NOP);

        // faults
        fetch(32'h2, 1'b0, 1'b0);
        chk("nofault_disabled", {31'b0, d_fault}, 32'd0);
        fetch(32'h2, 1'b1, 1'b1);
        chk("nofault_flush", {31'b0, d_fault}, 32'd0);
        fetch(32'h2, 1'b1, 1'b0);
        chk("misalign_data", d_data, NOP);
        chk("misalign_fault", {31'b0, d_fault}, 32'd1);
        fetch(32'h1000, 1'b1, 1'b0);
        chk("range_data", d_data, NOP);
        fetch(32'h0, 1'b1, 1'b0);
        chk("fault_sticky", {31'b0, d_fault}, 32'd1);

        // load_valid in RUN is refused
        lv = 1'b1; ld = 32'hBAD0_BAD0; ll = 1'b1;
        cyc();
        chk("run_ready", {31'b0, d_ready}, 32'd0);
        lv = 1'b0; ll = 1'b0;
        fetch(32'h0, 1'b1, 1'b0);
        chk("run_nowrite", d_data, 32'h00500093);

        // reload beats a same-cycle fetch
        rel = 1'b1;
        fetch(32'h8, 1'b1, 1'b0);
        rel = 1'b0;
        chk("reload_hold", {31'b0, d_hold}, 32'd1);
        chk("reload_data", d_data, NOP);
        chk("reload_count", {21'b0, d_count}, 32'd0);
        chk("reload_fault_kept", {31'b0, d_fault}, 32'd1);
        load_word(32'hDEADBEEF, 1'b1);
        fetch(32'h0, 1'b1, 1'b0);
        chk("reload_w0", d_data, 32'hDEADBEEF);
        fetch(32'h4, 1'b1, 1'b0);
        chk("reload_w1_kept", d_data, 32'h00100113);

        // random load with gaps, then random fetch traffic
        rel = 1'b1; cyc(); rel = 1'b0;
        for (int n = 0; n < 12; ) begin
            if ($urandom_range(0, 3) != 0) begin
                load_word($urandom, n == 11);
                n++;
            end else begin
                cyc();
            end
        end
        for (int k = 0; k < 300; k++) begin
            int unsigned r, idx;
            r   = $urandom_range(0, 15);
            idx = $urandom_range(0, 11);
            if (r == 0)      addr = idx * 4 + $urandom_range(1, 3);
            else if (r == 1) addr = $urandom | 32'h0000_1000;
            else             addr = idx * 4;
            en    = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 7) == 0);
            cyc();
        end
        en = 1'b0; flush = 1'b0;

        // reset in the middle of a load
        rel = 1'b1; cyc(); rel = 1'b0;
        load_word(32'h1234_5678, 1'b0);
        load_word(32'h9ABC_DEF0, 1'b0);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("midrst_count", {21'b0, d_count}, 32'd0);
        chk("midrst_hold", {31'b0, d_hold}, 32'd1);
        chk("midrst_noboot_hold", {31'b0, n_hold}, 32'd0);
        load_word(32'hCAFE_F00D, 1'b1);
        fetch(32'h0, 1'b1, 1'b0);
        chk("midrst_w0", d_data, 32'hCAFE_F00D);
        fetch(32'h4, 1'b1, 1'b0);
        chk("midrst_w1_partial", d_data, 32'h9ABC_DEF0);

        // small store: overflow, no wrap, saturation
        s_cyc();
        chk("s_rst_hold", {31'b0, s_hold}, 32'd1);
        chk("s_rst_count", {29'b0, s_count}, 32'd0);
        s_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_lv = 1'b1; s_ld = sw[i]; s_ll = (i == 5);
            s_cyc();
        end
        s_lv = 1'b0; s_ll = 1'b0;
        chk("s_ovf", {31'b0, s_ovf}, 32'd1);
        chk("s_count6", {29'b0, s_count}, 32'd6);
        chk("s_hold_done", {31'b0, s_hold}, 32'd0);
        s_en = 1'b1;
        s_addr = 32'h0; s_cyc(); chk("s_w0", s_data, sw[0]);
        s_addr = 32'h4; s_cyc(); chk("s_w1", s_data, sw[1]);
        s_addr = 32'hC; s_cyc(); chk("s_w3", s_data, sw[3]);
        s_addr = 32'h10; s_cyc();
        chk("s_range_data", s_data, NOP);
        chk("s_range_fault", {31'b0, s_fault}, 32'd1);
        s_en = 1'b0;
        s_lv = 1'b1; s_ld = 32'h7777; s_cyc();
        chk("s_run_ready", {31'b0, s_ready}, 32'd0);
        s_lv = 1'b0;
        s_en = 1'b1; s_addr = 32'h0; s_cyc(); chk("s_run_nowrite", s_data, sw[0]);
        s_en = 1'b0;
        s_rel = 1'b1; s_cyc(); s_rel = 1'b0;
        chk("s_reload_count", {29'b0, s_count}, 32'd0);
        chk("s_reload_ovf", {31'b0, s_ovf}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            s_lv = 1'b1; s_ld = 32'hA0 + i; s_ll = (i == 8);
            s_cyc();
        end
        s_lv = 1'b0; s_ll = 1'b0;
        chk("s_sat_count", {29'b0, s_count}, 32'd7);
        s_en = 1'b1;
        s_addr = 32'h0; s_cyc(); chk("s_new_w0", s_data, 32'hA0);
        s_addr = 32'hC; s_cyc(); chk("s_new_w3", s_data, 32'hA3);
        s_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
